// File: rtl/cache_miss_ctrl_pkg.sv
// cache_miss_ctrl_pkg: shared state encoding and datapath mux selects for the L1 miss controller.
package cache_miss_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    localparam logic ADDR_SEL_CPU    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;
    localparam logic DATA_SEL_PMEM   = 1'b0;
    localparam logic DATA_SEL_CPU    = 1'b1;
endpackage

// File: rtl/cache_perf_counter.sv
// cache_perf_counter: saturating event counter with synchronous clear (clear beats increment).
module cache_perf_counter
    import cache_miss_ctrl_pkg::*;
#(parameter int W = 16)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: 2-way L1 hit/writeback/fill control FSM.
// Define CACHE_PERF_CNT_EN to add hit/miss/writeback performance counters.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
`ifdef CACHE_PERF_CNT_EN
#(parameter int CNT_WIDTH = 16)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    input  logic       way0_hit,
    input  logic       way1_hit,
    input  logic       way0_dirty,
    input  logic       way1_dirty,
    input  logic       lru_in,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    output logic       pmem_addr_sel,
    output logic       victim_way,
    output logic       data_in_sel,
    output logic [1:0] load_data,
    output logic [1:0] load_tag,
    output logic [1:0] set_valid,
    output logic [1:0] set_dirty,
    output logic [1:0] clr_dirty,
    output logic       load_lru,
    output logic       lru_out
`ifdef CACHE_PERF_CNT_EN
    ,
    input  logic                 count_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);
    state_t state;
    logic req, hit, hit_way;
    assign req = mem_read | mem_write;
    assign hit = way0_hit | way1_hit;
    assign hit_way = ~way0_hit;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            victim_way <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req && !hit) begin
                    victim_way <= lru_in;
                    state      <= (lru_in ? way1_dirty : way0_dirty) ? WRITEBACK : FILL;
                end
                WRITEBACK: if (pmem_resp) state <= FILL;
                FILL:      if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    // Outputs are gated by reset so pmem strobes drop the moment reset rises.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = ADDR_SEL_CPU;
        data_in_sel   = DATA_SEL_PMEM;
        load_data     = 2'b00;
        load_tag      = 2'b00;
        set_valid     = 2'b00;
        set_dirty     = 2'b00;
        clr_dirty     = 2'b00;
        load_lru      = 1'b0;
        lru_out       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_out  = ~hit_way;
                    if (mem_write) begin
                        load_data[hit_way] = 1'b1;
                        set_dirty[hit_way] = 1'b1;
                        data_in_sel        = DATA_SEL_CPU;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = ADDR_SEL_VICTIM;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data[victim_way] = 1'b1;
                        load_tag[victim_way]  = 1'b1;
                        set_valid[victim_way] = 1'b1;
                        clr_dirty[victim_way] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef CACHE_PERF_CNT_EN
    logic miss_inc, wb_inc;
    assign miss_inc = state == IDLE && req && !hit;
    assign wb_inc   = state == WRITEBACK && pmem_resp;
    cache_perf_counter #(.W(CNT_WIDTH)) u_hit  (.clk(clk), .reset(reset), .clear(count_clear), .inc(mem_resp), .count(hit_count));
    cache_perf_counter #(.W(CNT_WIDTH)) u_miss (.clk(clk), .reset(reset), .clear(count_clear), .inc(miss_inc), .count(miss_count));
    cache_perf_counter #(.W(CNT_WIDTH)) u_wb   (.clk(clk), .reset(reset), .clear(count_clear), .inc(wb_inc),   .count(wb_count));
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: scoreboard bench for cache_miss_ctrl; CPU responses are checked against a queue of expected results.
module tb_cache_miss_ctrl;
    logic clk = 1'b0;
    logic reset, mem_read, mem_write, way0_hit, way1_hit, way0_dirty, way1_dirty, lru_in, pmem_resp;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, victim_way, data_in_sel, load_lru, lru_out;
    logic [1:0] load_data, load_tag, set_valid, set_dirty, clr_dirty;
`ifdef CACHE_PERF_CNT_EN
    logic count_clear;
    logic [15:0] hit_count, miss_count, wb_count;
`endif
    typedef struct packed {logic [1:0] ld; logic [1:0] sd; logic dsel; logic lru;} resp_t;
    resp_t sb[$];
    resp_t obs, exp_r;
    int checks = 0, fails = 0;
    logic [17:0] all_out;
    assign all_out = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, victim_way, data_in_sel,
                      load_data, load_tag, set_valid, set_dirty, clr_dirty, load_lru, lru_out};
    always #5 clk = ~clk;

    cache_miss_ctrl dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .way0_hit(way0_hit), .way1_hit(way1_hit), .way0_dirty(way0_dirty), .way1_dirty(way1_dirty),
        .lru_in(lru_in), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .pmem_addr_sel(pmem_addr_sel), .victim_way(victim_way), .data_in_sel(data_in_sel),
        .load_data(load_data), .load_tag(load_tag), .set_valid(set_valid), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .load_lru(load_lru), .lru_out(lru_out)
`ifdef CACHE_PERF_CNT_EN
        , .count_clear(count_clear), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {mem_read, mem_write, way0_hit, way1_hit, way0_dirty, way1_dirty, lru_in, pmem_resp} = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        mem_read = 1'b1;
        way0_hit = 1'b1;
        #3;
        checks++;
        if (all_out !== 18'h0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        step();
        reset = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (all_out !== 18'h0) begin fails++; $display("FAIL idle_no_request: got %h expected 0", all_out); end
    endtask

    task automatic test_hits();
        logic [3:0] stim [4] = '{4'b1001, 4'b0110, 4'b1011, 4'b1101};
        logic [5:0] want [4] = '{6'b000000, 6'b010111, 6'b000001, 6'b101010};
        for (int i = 0; i < 4; i++) begin
            step();
            idle_inputs();
            {mem_read, mem_write, way0_hit, way1_hit} = stim[i];
            sb.push_back(want[i]);
            #3;
            checks++;
            if ({mem_resp, load_lru, pmem_read, pmem_write} !== 4'b1100) begin
                fails++; $display("FAIL hit_%0d_strobes: got %b expected 1100", i, {mem_resp, load_lru, pmem_read, pmem_write});
            end
            if (mem_resp) begin
                exp_r = sb.pop_front();
                obs = {load_data, set_dirty, data_in_sel, lru_out};
                checks++;
                if (obs !== exp_r) begin fails++; $display("FAIL hit_%0d_resp: got %b expected %b", i, obs, exp_r); end
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_clean_miss();
        int k;
        step();
        mem_read = 1'b1; lru_in = 1'b1; way0_dirty = 1'b1; way1_dirty = 1'b0;
        sb.push_back(6'b000000);
        #3;
        checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin fails++; $display("FAIL clean_miss_cycle: got %b expected 000", {mem_resp, pmem_read, pmem_write}); end
        for (int i = 0; i < 3; i++) begin
            step();
            pmem_resp = (i == 2);
            #3;
            checks++;
            if ({pmem_read, pmem_write, pmem_addr_sel, data_in_sel, mem_resp} !== 5'b10000) begin
                fails++; $display("FAIL clean_fill_%0d: got %b expected 10000", i, {pmem_read, pmem_write, pmem_addr_sel, data_in_sel, mem_resp});
            end
        end
        checks++;
        if ({load_data, load_tag, set_valid, clr_dirty, set_dirty, victim_way} !== 11'b10101010001) begin
            fails++; $display("FAIL clean_fill_pulse: got %b expected 10101010001", {load_data, load_tag, set_valid, clr_dirty, set_dirty, victim_way});
        end
        step();
        pmem_resp = 1'b0;
        way1_hit = 1'b1;
        k = 0;
        #3;
        while (!mem_resp && k < 8) begin step(); #3; k++; end
        checks++;
        if (k !== 0) begin fails++; $display("FAIL clean_relookup_latency: got %0d extra cycles expected 0", k); end
        if (mem_resp) begin
            exp_r = sb.pop_front();
            obs = {load_data, set_dirty, data_in_sel, lru_out};
            checks++;
            if (obs !== exp_r) begin fails++; $display("FAIL clean_relookup_resp: got %b expected %b", obs, exp_r); end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_dirty_miss();
        int k;
        logic overlap = 1'b0;
        step();
        mem_write = 1'b1; lru_in = 1'b0; way0_dirty = 1'b1; way1_dirty = 1'b0;
        sb.push_back(6'b010111);
        #3;
        checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin fails++; $display("FAIL dirty_miss_cycle: got %b expected 000", {mem_resp, pmem_read, pmem_write}); end
        for (int i = 0; i < 3; i++) begin
            step();
            pmem_resp = (i == 2);
            #3;
            overlap |= pmem_read & pmem_write;
            checks++;
            if ({pmem_write, pmem_read, pmem_addr_sel, victim_way, load_data} !== 6'b101000) begin
                fails++; $display("FAIL writeback_%0d: got %b expected 101000", i, {pmem_write, pmem_read, pmem_addr_sel, victim_way, load_data});
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            pmem_resp = (i == 1);
            #3;
            overlap |= pmem_read & pmem_write;
            checks++;
            if ({pmem_write, pmem_read, pmem_addr_sel, data_in_sel} !== 4'b0100) begin
                fails++; $display("FAIL dirty_fill_%0d: got %b expected 0100", i, {pmem_write, pmem_read, pmem_addr_sel, data_in_sel});
            end
        end
        checks++;
        if ({load_data, load_tag, set_valid, clr_dirty, set_dirty} !== 10'b0101010100) begin
            fails++; $display("FAIL dirty_fill_pulse: got %b expected 0101010100", {load_data, load_tag, set_valid, clr_dirty, set_dirty});
        end
        step();
        pmem_resp = 1'b0;
        way0_hit = 1'b1;
        k = 0;
        #3;
        while (!mem_resp && k < 8) begin step(); #3; k++; end
        overlap |= pmem_read & pmem_write;
        checks++;
        if (k !== 0) begin fails++; $display("FAIL dirty_relookup_latency: got %0d extra cycles expected 0", k); end
        if (mem_resp) begin
            exp_r = sb.pop_front();
            obs = {load_data, set_dirty, data_in_sel, lru_out};
            checks++;
            if (obs !== exp_r) begin fails++; $display("FAIL dirty_relookup_resp: got %b expected %b", obs, exp_r); end
        end
        checks++;
        if (overlap !== 1'b0) begin fails++; $display("FAIL pmem_overlap: got %b expected 0", overlap); end
        step();
        idle_inputs();
    endtask

    task automatic test_idle_pmem_resp();
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        #3;
        checks++;
        if (all_out !== 18'h0) begin fails++; $display("FAIL idle_pmem_resp: got %h expected 0", all_out); end
    endtask

    task automatic test_reset_mid_wb();
        step();
        mem_read = 1'b1; lru_in = 1'b1; way1_dirty = 1'b1;
        step();
        #3;
        checks++;
        if ({pmem_write, pmem_addr_sel, victim_way} !== 3'b111) begin fails++; $display("FAIL pre_reset_wb: got %b expected 111", {pmem_write, pmem_addr_sel, victim_way}); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 18'h0) begin fails++; $display("FAIL async_reset_outputs: got %h expected 0", all_out); end
        step();
        reset = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (all_out !== 18'h0) begin fails++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
        step();
        mem_read = 1'b1;
        way0_hit = 1'b1;
        sb.push_back(6'b000001);
        #3;
        checks++;
        if (mem_resp !== 1'b1) begin fails++; $display("FAIL post_reset_hit: got %b expected 1", mem_resp); end
        if (mem_resp) begin
            exp_r = sb.pop_front();
            obs = {load_data, set_dirty, data_in_sel, lru_out};
            checks++;
            if (obs !== exp_r) begin fails++; $display("FAIL post_reset_resp: got %b expected %b", obs, exp_r); end
        end
        step();
        idle_inputs();
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_perf_counters();
        step();
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        mem_read = 1'b1; lru_in = 1'b0; way0_dirty = 1'b1;
        step();
        pmem_resp = 1'b1;
        step();
        step();
        pmem_resp = 1'b0;
        way0_hit = 1'b1;
        step();
        step();
        step();
        idle_inputs();
        #3;
        checks++;
        if ({hit_count, miss_count, wb_count} !== {16'd3, 16'd1, 16'd1}) begin
            fails++; $display("FAIL perf_counts: got %0d/%0d/%0d expected 3/1/1", hit_count, miss_count, wb_count);
        end
        step();
        count_clear = 1'b1;
        mem_read = 1'b1;
        way0_hit = 1'b1;
        step();
        count_clear = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if ({hit_count, miss_count, wb_count} !== 48'h0) begin
            fails++; $display("FAIL perf_clear: got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, wb_count);
        end
    endtask
`endif

    initial begin
`ifdef CACHE_PERF_CNT_EN
        count_clear = 1'b0;
`endif
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_idle_pmem_resp();
        test_reset_mid_wb();
`ifdef CACHE_PERF_CNT_EN
        test_perf_counters();
`endif
        checks++;
        if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
